// File: rtl/program_memory_loader.sv
// Purpose : byte-stream boot loader; packs LE bytes into words, writes program memory, then releases the core.
// Latency : 4th byte of a word accepted at edge k -> mem_we_o high in cycle k+1 (4 bytes / 5 cycles max).
// Backpressure: byte_ready_o low outside LEN_LO/LEN_HI/DATA; an offered byte is held by the source until accepted.
//
// Ports:
//   clk, reset (async, active-low)
//   start_i                       begin a new load (ignored while busy_o)
//   byte_valid_i/byte_i/byte_ready_o   byte stream, transfer = valid & ready
//   mem_we_o/mem_addr_o/mem_wdata_o    program memory write port (we qualifies addr/data)
//   words_loaded_o                count of words written in current/last load
//   busy_o/done_o/error_o         load status
//   cpu_run_o                     1 = core may run
module program_memory_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [15:0] words_loaded_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_run_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] index;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;   // first three bytes of the word being assembled
    logic        xfer;
    logic        start_ok;
    logic [15:0] len_full;

    assign xfer     = byte_valid_i & byte_ready_o;
    assign start_ok = start_i & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
    // Complete length as it will be once the high byte in flight is latched.
    assign len_full = {byte_i, len[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        cpu_run_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i) begin
                    if (len_full == 16'd0)                    state_nxt = S_DONE;
                    else if (len_full > 16'(MEMORY_DEPTH))    state_nxt = S_ERROR;
                    else                                      state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we_o = 1'b1;
                busy_o   = 1'b1;
                if ((index + 16'd1) == len) state_nxt = S_DONE;
                else                        state_nxt = S_DATA;
            end
            S_DONE: begin
                done_o    = 1'b1;
                cpu_run_o = 1'b1;
                if (start_i) state_nxt = S_LEN_LO;
            end
            S_ERROR: begin
                error_o = 1'b1;
                if (start_i) state_nxt = S_LEN_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len            <= 16'd0;
            index          <= 16'd0;
            byte_cnt       <= 2'd0;
            asm_word       <= 24'd0;
            words_loaded_o <= 16'd0;
            mem_addr_o     <= 32'd0;
            mem_wdata_o    <= 32'd0;
        end else begin
            if (start_ok) begin
                len            <= 16'd0;
                index          <= 16'd0;
                byte_cnt       <= 2'd0;
                words_loaded_o <= 16'd0;
            end
            if (xfer && (state == S_LEN_LO)) len[7:0]  <= byte_i;
            if (xfer && (state == S_LEN_HI)) len[15:8] <= byte_i;
            if (xfer && (state == S_DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: asm_word[7:0]   <= byte_i;
                    2'd1: asm_word[15:8]  <= byte_i;
                    2'd2: asm_word[23:16] <= byte_i;
                    default: begin
                        // Address/data are registered here so they are stable for the whole WRITE cycle.
                        mem_wdata_o <= {byte_i, asm_word};
                        mem_addr_o  <= BASE_ADDRESS + {14'd0, index, 2'b00};
                    end
                endcase
            end
            if (state == S_WRITE) begin
                index          <= index + 16'd1;
                words_loaded_o <= words_loaded_o + 16'd1;
            end
        end
    end

endmodule
